// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t ARB_R0 = 1'b0;
  localparam req_id_t ARB_R1 = 1'b1;

endpackage

// File: rtl/arb_wdog.sv
// Busy-cycle watchdog: counts while enabled, clears on request, flags the last
// allowed cycle so the arbiter can force an error completion.
module arb_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for CPU (R0) and DMA (R1) onto the single mem_controller
// data port, with level REN/WEN -> ACK handshake, ACK-low drain and watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_DATA_I,
  input  logic              R0_REN,
  input  logic              R0_WEN,
  output logic              R0_ACK,
  output logic              R0_ERR,
  output logic [DATA_W-1:0] R0_DATA_O,
  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_DATA_I,
  input  logic              R1_REN,
  input  logic              R1_WEN,
  output logic              R1_ACK,
  output logic              R1_ERR,
  output logic [DATA_W-1:0] R1_DATA_O,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_DATA_I,
  output logic              M_REN,
  output logic              M_WEN,
  input  logic              M_ACK,
  input  logic [DATA_W-1:0] M_DATA_O
);

  arb_state_t        state_q, state_d;
  req_id_t           gnt_q, gnt_d;
  req_id_t           prio_q, prio_d;
  req_id_t           pick;
  logic              req0, req1;
  logic              expire;
  logic              done;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_data_d;
  logic              m_ren_d, m_wen_d;
  logic              r0_ack_d, r0_err_d, r1_ack_d, r1_err_d;
  logic [DATA_W-1:0] r0_data_d, r1_data_d;

  assign req0 = R0_REN | R0_WEN;
  assign req1 = R1_REN | R1_WEN;
  assign pick = (req0 && req1) ? prio_q : (req1 ? ARB_R1 : ARB_R0);
  // A real ACK in the expiry cycle still counts as a normal completion.
  assign done = (state_q == BUSY) && (M_ACK || expire);

  arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != BUSY),
    .en    (state_q == BUSY),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= ARB_R0;
      prio_q    <= ARB_R0;
      M_ADDR    <= '0;
      M_DATA_I  <= '0;
      M_REN     <= 1'b0;
      M_WEN     <= 1'b0;
      R0_ACK    <= 1'b0;
      R0_ERR    <= 1'b0;
      R0_DATA_O <= '0;
      R1_ACK    <= 1'b0;
      R1_ERR    <= 1'b0;
      R1_DATA_O <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      M_ADDR    <= m_addr_d;
      M_DATA_I  <= m_data_d;
      M_REN     <= m_ren_d;
      M_WEN     <= m_wen_d;
      R0_ACK    <= r0_ack_d;
      R0_ERR    <= r0_err_d;
      R0_DATA_O <= r0_data_d;
      R1_ACK    <= r1_ack_d;
      R1_ERR    <= r1_err_d;
      R1_DATA_O <= r1_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!M_ACK && (req0 || req1)) state_d = BUSY;
      BUSY:    if (M_ACK || expire) state_d = DRAIN;
      DRAIN:   if (!M_ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    m_addr_d  = M_ADDR;
    m_data_d  = M_DATA_I;
    m_ren_d   = M_REN;
    m_wen_d   = M_WEN;
    r0_ack_d  = 1'b0;
    r0_err_d  = 1'b0;
    r1_ack_d  = 1'b0;
    r1_err_d  = 1'b0;
    r0_data_d = R0_DATA_O;
    r1_data_d = R1_DATA_O;
    if (state_q == IDLE && !M_ACK && (req0 || req1)) begin
      gnt_d = pick;
      // WEN wins when a requester raises both enables.
      if (pick == ARB_R1) begin
        m_addr_d = R1_ADDR;
        m_data_d = R1_DATA_I;
        m_wen_d  = R1_WEN;
        m_ren_d  = R1_REN & ~R1_WEN;
      end else begin
        m_addr_d = R0_ADDR;
        m_data_d = R0_DATA_I;
        m_wen_d  = R0_WEN;
        m_ren_d  = R0_REN & ~R0_WEN;
      end
    end
    if (done) begin
      m_ren_d = 1'b0;
      m_wen_d = 1'b0;
      prio_d  = ~gnt_q;
      if (gnt_q == ARB_R1) begin
        r1_ack_d = 1'b1;
        r1_err_d = ~M_ACK;
        if (M_ACK && M_REN) r1_data_d = M_DATA_O;
      end else begin
        r0_ack_d = 1'b1;
        r0_err_d = ~M_ACK;
        if (M_ACK && M_REN) r0_data_d = M_DATA_O;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset and round-robin
// sequences, then randomized two-requester traffic against a reference memory.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] R0_ADDR, R1_ADDR, M_ADDR;
  logic [DW-1:0] R0_DATA_I, R1_DATA_I, R0_DATA_O, R1_DATA_O, M_DATA_I, M_DATA_O;
  logic          R0_REN, R0_WEN, R0_ACK, R0_ERR;
  logic          R1_REN, R1_WEN, R1_ACK, R1_ERR;
  logic          M_REN, M_WEN, M_ACK;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .R0_ADDR  (R0_ADDR),
    .R0_DATA_I(R0_DATA_I),
    .R0_REN   (R0_REN),
    .R0_WEN   (R0_WEN),
    .R0_ACK   (R0_ACK),
    .R0_ERR   (R0_ERR),
    .R0_DATA_O(R0_DATA_O),
    .R1_ADDR  (R1_ADDR),
    .R1_DATA_I(R1_DATA_I),
    .R1_REN   (R1_REN),
    .R1_WEN   (R1_WEN),
    .R1_ACK   (R1_ACK),
    .R1_ERR   (R1_ERR),
    .R1_DATA_O(R1_DATA_O),
    .M_ADDR   (M_ADDR),
    .M_DATA_I (M_DATA_I),
    .M_REN    (M_REN),
    .M_WEN    (M_WEN),
    .M_ACK    (M_ACK),
    .M_DATA_O (M_DATA_O)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    bit          both;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          rid;
    bit          we;
    bit          both;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          noack;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  // requester work queues; driver advances served[], main only appends
  txn_t rq [2][$];
  int   served [2];
  bit   drv_act [2];

  // memory-side configuration and storage
  int          mem_lat;
  bit          mem_noack;
  bit          rand_mode;
  logic [31:0] mem [logic [31:0]];
  int          m_cnt, m_dcnt, cur_lat, cur_drain;

  // reference state kept by the monitor
  logic [31:0] refm [logic [31:0]];
  logic [31:0] rd_m [2];
  int          last_ack;
  bit          other_req;
  int          ack_log [$];
  logic        mack_e, en_prev;
  logic [1:0]  req_e, ack_prev;
  logic [31:0] m_addr_prev, m_data_prev;

  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // requester driver: hold request level until ACK, drop the cycle after it
  always @(negedge clk) begin
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        drv_act[i] = 1'b0;
        served[i]  = rq[i].size();
      end else if (drv_act[i] && ((i == 0) ? R0_ACK : R1_ACK)) begin
        drv_act[i] = 1'b0;
        served[i]  = served[i] + 1;
      end else if (!drv_act[i] && served[i] < rq[i].size()) begin
        drv_act[i] = 1'b1;
      end
    end
    if (drv_act[0]) begin
      t = rq[0][served[0]];
      R0_ADDR = t.addr; R0_DATA_I = t.wdata; R0_WEN = t.we; R0_REN = !t.we || t.both;
    end else begin
      R0_REN = 1'b0; R0_WEN = 1'b0;
    end
    if (drv_act[1]) begin
      t = rq[1][served[1]];
      R1_ADDR = t.addr; R1_DATA_I = t.wdata; R1_WEN = t.we; R1_REN = !t.we || t.both;
    end else begin
      R1_REN = 1'b0; R1_WEN = 1'b0;
    end
  end

  // memory controller model: ACK after a latency, hold until enables drop
  always @(negedge clk) begin
    if (rst) begin
      M_ACK = 1'b0; m_cnt = 0; m_dcnt = 0;
    end else if (M_REN || M_WEN) begin
      m_dcnt = 0;
      if (!M_ACK) begin
        if (m_cnt == 0) begin
          cur_lat   = rand_mode ? int'($urandom_range(1, 6)) : mem_lat;
          cur_drain = rand_mode ? int'($urandom_range(0, 2)) : 0;
        end
        m_cnt = m_cnt + 1;
        if (!mem_noack && m_cnt >= cur_lat) begin
          M_ACK = 1'b1;
          if (M_WEN) mem[M_ADDR] = M_DATA_I;
          else M_DATA_O = mem.exists(M_ADDR) ? mem[M_ADDR] : 32'h0;
        end
      end
    end else begin
      m_cnt = 0;
      if (M_ACK) begin
        if (m_dcnt >= cur_drain) begin
          M_ACK = 1'b0; M_DATA_O = $urandom; m_dcnt = 0;
        end else begin
          m_dcnt = m_dcnt + 1;
        end
      end
    end
  end

  // one clock step with protocol and reference checks at posedge+1
  task automatic tick();
    logic [1:0] ack;
    logic       en;
    txn_t       t;
    @(posedge clk);
    mack_e = M_ACK;
    req_e  = {R1_REN | R1_WEN, R0_REN | R0_WEN};
    #1;
    if (rst) begin
      rd_m[0] = '0; rd_m[1] = '0;
      last_ack = -1; other_req = 1'b0;
      en_prev = 1'b0; ack_prev = 2'b00;
      return;
    end
    ack = {R1_ACK, R0_ACK};
    en  = M_REN | M_WEN;
    check("err_only_with_ack", {62'b0, {R1_ERR, R0_ERR} & ~ack}, 64'h0);
    if (en && !en_prev) begin
      check("en_rise_after_ack_low", {63'b0, mack_e}, 64'h0);
      check("en_rise_needs_req", {63'b0, req_e != 2'b00}, 64'h1);
    end
    if (en && en_prev) begin
      check("m_addr_stable", {32'b0, M_ADDR}, {32'b0, m_addr_prev});
      check("m_data_stable", {32'b0, M_DATA_I}, {32'b0, m_data_prev});
    end
    if (ack != 2'b00) begin
      check("ack_exclusive", {63'b0, ack == 2'b11}, 64'h0);
      check("ack_one_cycle", {62'b0, ack & ack_prev}, 64'h0);
    end
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) begin
        check($sformatf("ack_r%0d_expected", i), {63'b0, served[i] < rq[i].size()}, 64'h1);
        if (served[i] < rq[i].size()) begin
          t = rq[i][served[i]];
          check($sformatf("err_r%0d", i), {63'b0, (i == 0) ? R0_ERR : R1_ERR}, {63'b0, mem_noack});
          if (!mem_noack) begin
            if (t.we) refm[t.addr] = t.wdata;
            else rd_m[i] = refm.exists(t.addr) ? refm[t.addr] : 32'h0;
          end
        end
        check($sformatf("rr_fair_r%0d", i), {63'b0, last_ack == i && other_req}, 64'h0);
        last_ack  = i;
        other_req = req_e[1-i];
        ack_log.push_back(i);
      end
    end
    if (ack != 2'b00) begin
      check("r0_data_o", {32'b0, R0_DATA_O}, {32'b0, rd_m[0]});
      check("r1_data_o", {32'b0, R1_DATA_O}, {32'b0, rd_m[1]});
    end
    en_prev     = en;
    ack_prev    = ack;
    m_addr_prev = M_ADDR;
    m_data_prev = M_DATA_I;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    txn_t t;
    int   n;
    bit   got;
    mem_lat   = v.lat;
    mem_noack = v.noack;
    t.we = v.we; t.both = v.both; t.addr = v.addr; t.wdata = v.wdata;
    rq[v.rid].push_back(t);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        check($sformatf("v%0d_m_wen", idx), {63'b0, M_WEN}, {63'b0, v.we});
        check($sformatf("v%0d_m_ren", idx), {63'b0, M_REN}, {63'b0, !v.we});
        check($sformatf("v%0d_m_addr", idx), {32'b0, M_ADDR}, {32'b0, v.addr});
        if (v.we) check($sformatf("v%0d_m_data_i", idx), {32'b0, M_DATA_I}, {32'b0, v.wdata});
      end
      got = (v.rid == 0) ? R0_ACK : R1_ACK;
    end
    check($sformatf("v%0d_ack_cycle", idx), 64'(n), 64'(v.exp_cyc));
    if (got) begin
      check($sformatf("v%0d_err", idx), {63'b0, (v.rid == 0) ? R0_ERR : R1_ERR}, {63'b0, v.exp_err});
      check($sformatf("v%0d_en_dropped", idx), {63'b0, M_REN | M_WEN}, 64'h0);
      if (!v.exp_err && !v.we)
        check($sformatf("v%0d_rdata", idx), {32'b0, (v.rid == 0) ? R0_DATA_O : R1_DATA_O},
              {32'b0, v.exp_data});
    end
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    int   exp_rr [4];
    int   k;
    bit   saw_ack;
    txn_t t;

    vecs[0] = '{0, 1, 0, 32'h100, 32'h12345678, 3, 0, 4, 0, 32'h0};
    vecs[1] = '{1, 0, 0, 32'h100, 32'h0,        2, 0, 3, 0, 32'h12345678};
    vecs[2] = '{0, 0, 0, 32'h100, 32'h0,        1, 0, 2, 0, 32'h12345678};
    vecs[3] = '{1, 1, 1, 32'h200, 32'hCAFEF00D, 1, 0, 2, 0, 32'h0};
    vecs[4] = '{0, 0, 0, 32'h200, 32'h0,        5, 0, 6, 0, 32'hCAFEF00D};
    vecs[5] = '{0, 0, 0, 32'h300, 32'h0,        1, 1, 9, 1, 32'h0};
    vecs[6] = '{1, 1, 0, 32'h300, 32'hDEADBEEF, 1, 1, 9, 1, 32'h0};
    vecs[7] = '{1, 0, 0, 32'h100, 32'h0,        8, 0, 9, 0, 32'h12345678};
    vecs[8] = '{0, 0, 0, 32'h300, 32'h0,        7, 0, 8, 0, 32'h0};
    exp_rr  = '{0, 1, 0, 1};

    checks = 0; errors = 0;
    served[0] = 0; served[1] = 0;
    drv_act[0] = 1'b0; drv_act[1] = 1'b0;
    rst = 1'b1;
    R0_ADDR = '0; R0_DATA_I = '0; R0_REN = 1'b0; R0_WEN = 1'b0;
    R1_ADDR = '0; R1_DATA_I = '0; R1_REN = 1'b0; R1_WEN = 1'b0;
    M_ACK = 1'b0; M_DATA_O = '0;
    mem_lat = 3; mem_noack = 1'b0; rand_mode = 1'b0;
    m_cnt = 0; m_dcnt = 0; cur_lat = 1; cur_drain = 0;
    last_ack = -1; other_req = 1'b0;

    // reset state
    repeat (2) tick();
    check("rst_ctrl_outputs", {58'b0, R0_ACK, R0_ERR, R1_ACK, R1_ERR, M_REN, M_WEN}, 64'h0);
    check("rst_m_addr_data", {M_ADDR, M_DATA_I}, 64'h0);
    check("rst_r_data_o", {R0_DATA_O, R1_DATA_O}, 64'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_req", {60'b0, M_REN, M_WEN, R0_ACK, R1_ACK}, 64'h0);

    // directed vector table
    foreach (vecs[i]) run_vec(vecs[i], i);
    mem_noack = 1'b0;

    // simultaneous requests alternate starting with R0 after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_lat = 2;
    ack_log.delete();
    t = '{1, 0, 32'h40, 32'hA0A0A0A0}; rq[0].push_back(t);
    t = '{1, 0, 32'h44, 32'hB1B1B1B1}; rq[1].push_back(t);
    t = '{0, 0, 32'h44, 32'h0};        rq[0].push_back(t);
    t = '{0, 0, 32'h40, 32'h0};        rq[1].push_back(t);
    k = 0;
    while (ack_log.size() < 4 && k < 200) begin
      tick();
      k++;
    end
    check("rr_ack_count", 64'(ack_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < ack_log.size()) check($sformatf("rr_order_%0d", i), 64'(ack_log[i]), 64'(exp_rr[i]));
    check("rr_r0_read_b1", {32'b0, R0_DATA_O}, 64'hB1B1B1B1);
    check("rr_r1_read_a0", {32'b0, R1_DATA_O}, 64'hA0A0A0A0);
    repeat (3) tick();

    // reset while BUSY drops enables asynchronously, no ACK afterwards
    mem_noack = 1'b1;
    t = '{0, 0, 32'h8, 32'h0}; rq[0].push_back(t);
    repeat (4) tick();
    check("busy_before_rst", {63'b0, M_REN}, 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_drop_en", {62'b0, M_REN, M_WEN}, 64'h0);
    check("rst_no_ack", {62'b0, R0_ACK, R1_ACK}, 64'h0);
    repeat (2) tick();
    rst = 1'b0;
    saw_ack = 1'b0;
    repeat (12) begin
      tick();
      saw_ack = saw_ack | R0_ACK | R1_ACK;
    end
    check("no_ack_after_rst", {63'b0, saw_ack}, 64'h0);
    check("idle_after_rst", {62'b0, M_REN, M_WEN}, 64'h0);
    mem_noack = 1'b0;

    // randomized two-requester traffic
    rand_mode = 1'b1;
    repeat (400) begin
      tick();
      #2;
      if ($urandom_range(0, 3) == 0) begin
        t.we    = $urandom_range(0, 1) == 1;
        t.both  = t.we && ($urandom_range(0, 1) == 1);
        t.addr  = {28'b0, 2'($urandom_range(0, 3)), 2'b00};
        t.wdata = $urandom;
        rq[$urandom_range(0, 1)].push_back(t);
      end
    end
    k = 0;
    while ((served[0] < rq[0].size() || served[1] < rq[1].size()) && k < 3000) begin
      tick();
      k++;
    end
    check("random_all_served", {63'b0, k < 3000}, 64'h1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
